int_div_unit: RTL and testbench

- Multi-cycle iterative radix-2 integer divider for the RV32M ops DIV, DIVU, REM and REMU, located in the EX stage.
- It is the responder for the divide handshake: the EX/MEM pipeline register raises IDiv to start a divide and remembers rd, then reconstructs writeback controls when this block pulses div_done.
- It drives div_busy so hazard logic can stall the front end while the divide runs.

---
 rtl/int_div_unit.sv | 118 +++++++++++
 tb/tb_int_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with a sign-fix cycle; divide-by-zero and signed overflow resolve in one cycle.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            IDiv,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic [XLEN-1:0] div_result,
  output logic            div_done,
  output logic            div_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            q_neg_q, r_neg_q, is_rem_q;

  logic            accept, is_signed, is_rem, a_neg, b_neg;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN:0]   rem_sh, trial;
  logic            trial_ge;
  logic [XLEN-1:0] rem_next, quo_next, fix_res;

  // Operand conditioning and special-case detection on the raw inputs
  assign is_signed   = ~div_op[0];
  assign is_rem      = div_op[1];
  assign a_neg       = is_signed & dividend[XLEN-1];
  assign b_neg       = is_signed & divisor[XLEN-1];
  assign abs_a       = a_neg ? -dividend : dividend;
  assign abs_b       = b_neg ? -divisor : divisor;
  assign div_zero    = (divisor == '0);
  assign ovf         = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign special     = div_zero | ovf;
  assign special_res = div_zero ? (is_rem ? dividend : '1)
                                : (is_rem ? '0 : dividend);

  // Restoring step: a borrow out of the XLEN+1-bit trial means "does not fit"
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvsr_q};
  assign trial_ge = ~trial[XLEN];
  assign rem_next = trial_ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_next = {quo_q[XLEN-2:0], trial_ge};

  assign fix_res = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                            : (q_neg_q ? -quo_q : quo_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (IDiv && !flush) begin
          accept  = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush)                              state_d = IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))     state_d = FIX;
      end
      FIX:     state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_done = (state_q == DONE);
  assign div_busy = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      div_result <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= '0;
        rem_q    <= '0;
        quo_q    <= abs_a;
        dvsr_q   <= abs_b;
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
        is_rem_q <= is_rem;
        if (special) div_result <= special_res;
      end else if (state_q == CALC && !flush) begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= rem_next;
        quo_q <= quo_next;
      end else if (state_q == FIX && !flush) begin
        div_result <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_int_div_unit.sv
// Scoreboard bench for int_div_unit: the driver queues expected result/arrival cycle,
// a negedge monitor pops and compares whenever div_done pulses.
module tb_int_div_unit;

  localparam int XLEN = 32;

  logic            CLK;
  logic            rst;
  logic            IDiv;
  logic [1:0]      div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic [XLEN-1:0] div_result;
  logic            div_done;
  logic            div_busy;

  int_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .IDiv      (IDiv),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .div_result(div_result),
    .div_done  (div_done),
    .div_busy  (div_busy)
  );

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [XLEN-1:0] last_exp;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every div_done must match the oldest outstanding expectation
  always @(negedge CLK) begin
    exp_t e;
    if (!rst && div_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h with nothing outstanding", div_result);
      end else begin
        e = sb.pop_front();
        check("result", div_result, e.res);
        check("latency_cycle", XLEN'(cyc), XLEN'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge CLK);
    IDiv     = 1'b1;
    div_op   = op;
    dividend = a;
    divisor  = b;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat, input bit repulse);
    exp_t e;
    int   busy_cnt;
    bit   got;
    issue(op, a, b);
    e.res = exp;
    e.cyc = cyc + lat;
    sb.push_back(e);
    last_exp = exp;
    @(negedge CLK);
    IDiv     = 1'b0;
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (div_busy) busy_cnt++;
      if (div_done) got = 1'b1;
      else begin
        if (repulse && i == 5) begin
          IDiv = 1'b1; div_op = OP_DIVU; dividend = 32'd77; divisor = 32'd5;
        end else IDiv = 1'b0;
        @(negedge CLK);
      end
    end
    check("done_seen", XLEN'(got), XLEN'(1));
    check("busy_cycles", XLEN'(busy_cnt), XLEN'(lat));
    if (!got) sb.delete();
    if (repulse) begin
      IDiv = 1'b1; div_op = OP_REMU; dividend = 32'd55; divisor = 32'd6;
      @(negedge CLK);
      IDiv = 1'b0;
      check("repulse_done_busy", XLEN'(div_busy), XLEN'(0));
    end
  endtask

  initial begin
    rst = 1'b1; IDiv = 1'b0; div_op = 2'b00; dividend = '0; divisor = '0; flush = 1'b0;
    last_exp = '0;
    repeat (2) @(negedge CLK);
    check("reset_result", div_result, '0);
    check("reset_done", XLEN'(div_done), XLEN'(0));
    check("reset_busy", XLEN'(div_busy), XLEN'(0));
    rst = 1'b0;

    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op(OP_DIV,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34, 1'b0);
    run_op(OP_REM,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34, 1'b0);
    run_op(OP_REM,  32'd20, 32'hFFFFFFFD, 32'd2, 34, 1'b0);
    run_op(OP_DIV,  32'h12345678, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op(OP_REMU, 32'h12345678, 32'd0, 32'h12345678, 1, 1'b0);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
    run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, 1'b0);
    run_op(OP_DIV,  32'h80000000, 32'd2, 32'hC0000000, 34, 1'b0);
    run_op(OP_DIV,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34, 1'b1);

    // Flush in the tenth CALC cycle: nothing may complete, result untouched
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge CLK);
    IDiv = 1'b0;
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", XLEN'(div_busy), XLEN'(0));
    check("flush_done", XLEN'(div_done), XLEN'(0));
    check("flush_result_kept", div_result, last_exp);
    repeat (40) @(negedge CLK);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    // Reset mid-CALC
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge CLK);
    IDiv = 1'b0;
    repeat (5) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    check("midrst_busy", XLEN'(div_busy), XLEN'(0));
    check("midrst_done", XLEN'(div_done), XLEN'(0));
    check("midrst_result", div_result, '0);
    rst = 1'b0;
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34, 1'b0);

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", XLEN'(sb.size()), XLEN'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
